// File: rtl/ex_stage_unit_if.sv
// rtl/ex_stage_unit_if.sv - ID/EX operand side and EX/MEM result side of the execute stage
interface ex_stage_unit_if #(
  parameter int WIDTH = 16
);
  logic             flush;
  logic             halt;
  logic [WIDTH-1:0] write_back_ctrl_sgnl;
  logic [WIDTH-1:0] memory_ctrl_sgnl;
  logic [WIDTH-1:0] execute_ctrl_sgnl;
  logic [WIDTH-1:0] reg_1_buff;
  logic [WIDTH-1:0] reg_2_buff;
  logic [WIDTH-1:0] sign_extended_buff;
  logic [WIDTH-1:0] instruction_buff;
  logic [WIDTH-1:0] write_back_ctrl_sgnl_out;
  logic [WIDTH-1:0] memory_ctrl_sgnl_out;
  logic [WIDTH-1:0] alu_result_out;
  logic [WIDTH-1:0] alu_hi_out;
  logic [WIDTH-1:0] store_data_out;
  logic [3:0]       dest_reg_out;
  logic             zero_out;
  logic             valid_out;
  logic             stall_out;

  modport slave (
    input  flush, halt, write_back_ctrl_sgnl, memory_ctrl_sgnl, execute_ctrl_sgnl,
           reg_1_buff, reg_2_buff, sign_extended_buff, instruction_buff,
    output write_back_ctrl_sgnl_out, memory_ctrl_sgnl_out, alu_result_out, alu_hi_out,
           store_data_out, dest_reg_out, zero_out, valid_out, stall_out
  );

  modport master (
    output flush, halt, write_back_ctrl_sgnl, memory_ctrl_sgnl, execute_ctrl_sgnl,
           reg_1_buff, reg_2_buff, sign_extended_buff, instruction_buff,
    input  write_back_ctrl_sgnl_out, memory_ctrl_sgnl_out, alu_result_out, alu_hi_out,
           store_data_out, dest_reg_out, zero_out, valid_out, stall_out
  );
endinterface

// File: rtl/ex_stage_unit.sv
// rtl/ex_stage_unit.sv - execute stage: single-cycle ALU plus iterative MUL/DIVU into EX/MEM
module ex_stage_unit #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input logic            clk,
  input logic            rst,
  ex_stage_unit_if.slave bus
);
  localparam int CW = $clog2(ITERS);
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] hi_r, hi_d, lo_r, lo_d, b_r, b_d;
  logic             div_r, div_d;

  logic [WIDTH-1:0] wb_q, mem_q, res_q, hiout_q, sd_q;
  logic [WIDTH-1:0] wb_d, mem_d, res_d, hiout_d, sd_d;
  logic [3:0]       dest_q, dest_d;
  logic             zero_q, zero_d, valid_q, valid_d;
  logic             stall;

  logic [3:0]       op;
  logic             in_valid, is_multi;
  logic [WIDTH-1:0] opa, opb, alu_res;
  logic             unused_bits;

  assign op          = bus.execute_ctrl_sgnl[3:0];
  assign in_valid    = bus.execute_ctrl_sgnl[5];
  assign opa         = bus.reg_1_buff;
  assign opb         = bus.execute_ctrl_sgnl[4] ? bus.sign_extended_buff : bus.reg_2_buff;
  assign is_multi    = (op == OP_MUL) || (op == OP_DIVU);
  assign unused_bits = ^{bus.execute_ctrl_sgnl[WIDTH-1:6], bus.instruction_buff[WIDTH-1:12],
                         bus.instruction_buff[7:0]};

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0: alu_res = opa + opb;
      4'd1: alu_res = opa - opb;
      4'd2: alu_res = opa & opb;
      4'd3: alu_res = opa | opb;
      4'd4: alu_res = opa ^ opb;
      4'd5: alu_res = opa << opb[3:0];
      4'd6: alu_res = opa >> opb[3:0];
      4'd7: alu_res = $signed(opa) >>> opb[3:0];
      4'd8: alu_res = ($signed(opa) < $signed(opb)) ? WIDTH'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  // One iteration: shift-add keeps the product in hi:lo; restoring divide shifts quotient bits into lo.
  logic [WIDTH:0]   mul_sum, div_r17, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    div_r17  = {hi_r, lo_r[WIDTH-1]};
    div_diff = div_r17 - {1'b0, b_r};
    div_ge   = (div_r17 >= {1'b0, b_r});
    if (div_r) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_r17[WIDTH-1:0];
      step_lo = {lo_r[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_r[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi_r;
    lo_d    = lo_r;
    b_d     = b_r;
    div_d   = div_r;
    wb_d    = '0;
    mem_d   = '0;
    res_d   = '0;
    hiout_d = '0;
    sd_d    = '0;
    dest_d  = '0;
    zero_d  = 1'b0;
    valid_d = 1'b0;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && is_multi) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = opa;
          b_d     = opb;
          div_d   = (op == OP_DIVU);
        end else if (in_valid) begin
          wb_d    = bus.write_back_ctrl_sgnl;
          mem_d   = bus.memory_ctrl_sgnl;
          res_d   = alu_res;
          sd_d    = bus.reg_2_buff;
          dest_d  = bus.instruction_buff[11:8];
          zero_d  = (alu_res == '0);
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(ITERS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        wb_d    = bus.write_back_ctrl_sgnl;
        mem_d   = bus.memory_ctrl_sgnl;
        res_d   = lo_r;
        hiout_d = hi_r;
        sd_d    = bus.reg_2_buff;
        dest_d  = bus.instruction_buff[11:8];
        zero_d  = (lo_r == '0);
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bus.halt && state != IDLE) stall = 1'b1;
    if (bus.flush) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      b_r     <= '0;
      div_r   <= 1'b0;
      wb_q    <= '0;
      mem_q   <= '0;
      res_q   <= '0;
      hiout_q <= '0;
      sd_q    <= '0;
      dest_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (!bus.halt) begin
      state   <= state_d;
      cnt     <= cnt_d;
      hi_r    <= hi_d;
      lo_r    <= lo_d;
      b_r     <= b_d;
      div_r   <= div_d;
      wb_q    <= wb_d;
      mem_q   <= mem_d;
      res_q   <= res_d;
      hiout_q <= hiout_d;
      sd_q    <= sd_d;
      dest_q  <= dest_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.write_back_ctrl_sgnl_out = wb_q;
  assign bus.memory_ctrl_sgnl_out     = mem_q;
  assign bus.alu_result_out           = res_q;
  assign bus.alu_hi_out               = hiout_q;
  assign bus.store_data_out           = sd_q;
  assign bus.dest_reg_out             = dest_q;
  assign bus.zero_out                 = zero_q;
  assign bus.valid_out                = valid_q;
  assign bus.stall_out                = stall;
endmodule

// File: tb/tb_ex_stage_unit.sv
// tb/tb_ex_stage_unit.sv - directed-vector bench for the execute stage
module tb_ex_stage_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  ex_stage_unit_if bus();
  ex_stage_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic valid, input logic src,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    bus.execute_ctrl_sgnl    = {10'd0, valid, src, op};
    bus.reg_1_buff           = a;
    bus.reg_2_buff           = b;
    bus.sign_extended_buff   = imm;
    bus.write_back_ctrl_sgnl = valid ? 16'h1111 : 16'h0000;
    bus.memory_ctrl_sgnl     = valid ? 16'h2222 : 16'h0000;
    bus.instruction_buff     = valid ? 16'h0A00 : 16'h0000;
    #1;
  endtask

  task automatic bubble();
    drive(4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic test_reset();
    bus.flush = 1'b0;
    bus.halt  = 1'b0;
    bubble();
    rst = 1'b1;
    step();
    step();
    nvec++;
    if ({bus.write_back_ctrl_sgnl_out, bus.memory_ctrl_sgnl_out, bus.alu_result_out,
         bus.alu_hi_out, bus.store_data_out, bus.dest_reg_out, bus.zero_out,
         bus.valid_out, bus.stall_out} !== 87'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got res=%h hi=%h valid=%b stall=%b, required all zero",
               bus.alu_result_out, bus.alu_hi_out, bus.valid_out, bus.stall_out);
    end
    rst = 1'b0;
  endtask

  task automatic single(input string name, input logic [3:0] op, input logic src,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                        input logic [15:0] exp_res);
    drive(op, 1'b1, src, a, b, imm);
    nvec++;
    if (bus.stall_out !== 1'b0) begin
      nerr++;
      $display("FAIL %s_stall: got %b, required 0", name, bus.stall_out);
    end
    step();
    nvec++;
    if (bus.alu_result_out !== exp_res || bus.zero_out !== (exp_res == 16'h0) ||
        bus.valid_out !== 1'b1 || bus.alu_hi_out !== 16'h0 || bus.store_data_out !== b ||
        bus.dest_reg_out !== 4'hA || bus.write_back_ctrl_sgnl_out !== 16'h1111 ||
        bus.memory_ctrl_sgnl_out !== 16'h2222) begin
      nerr++;
      $display("FAIL %s: got res=%h zero=%b valid=%b hi=%h sd=%h dest=%h wb=%h mem=%h, required res=%h zero=%b valid=1 hi=0 sd=%h dest=a wb=1111 mem=2222",
               name, bus.alu_result_out, bus.zero_out, bus.valid_out, bus.alu_hi_out,
               bus.store_data_out, bus.dest_reg_out, bus.write_back_ctrl_sgnl_out,
               bus.memory_ctrl_sgnl_out, exp_res, exp_res == 16'h0, b);
    end
  endtask

  task automatic test_single_cycle();
    single("add", 4'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000);
    single("sub_imm", 4'd1, 1'b1, 16'h0005, 16'h0009, 16'h0005, 16'h0000);
    single("slt", 4'd8, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001);
    single("sra", 4'd7, 1'b0, 16'h8000, 16'h0004, 16'h0000, 16'hF800);
    single("sll", 4'd5, 1'b1, 16'h0003, 16'h0000, 16'h0004, 16'h0030);
    single("xor", 4'd4, 1'b0, 16'hF0F0, 16'h0FF0, 16'h0000, 16'hFF00);
    single("op12", 4'd12, 1'b0, 16'h1234, 16'h4321, 16'h0000, 16'h0000);
    bubble();
    step();
    nvec++;
    if (bus.valid_out !== 1'b0 || bus.write_back_ctrl_sgnl_out !== 16'h0 ||
        bus.alu_result_out !== 16'h0) begin
      nerr++;
      $display("FAIL bubble: got valid=%b wb=%h res=%h, required 0 0 0",
               bus.valid_out, bus.write_back_ctrl_sgnl_out, bus.alu_result_out);
    end
  endtask

  // Runs one multi-cycle op with optional halt window over edges [h0, h0+hn).
  task automatic multi(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_lo, input logic [15:0] exp_hi,
                       input int h0, input int hn);
    int total, stalls, early;
    total  = 18 + hn;
    stalls = 0;
    early  = 0;
    drive(op, 1'b1, 1'b0, a, b, 16'h0);
    for (int i = 1; i <= total; i++) begin
      bus.halt = (hn > 0) && (i >= h0) && (i < h0 + hn);
      #1;
      if (bus.stall_out === 1'b1) stalls++;
      step();
      if (i < total && bus.valid_out !== 1'b0) early++;
    end
    bus.halt = 1'b0;
    nvec++;
    if (stalls != 17 + hn) begin
      nerr++;
      $display("FAIL %s_stall_cycles: got %0d, required %0d", name, stalls, 17 + hn);
    end
    nvec++;
    if (early != 0) begin
      nerr++;
      $display("FAIL %s_bubbles: got %0d non-bubble slots, required 0", name, early);
    end
    nvec++;
    if (bus.valid_out !== 1'b1 || bus.alu_result_out !== exp_lo || bus.alu_hi_out !== exp_hi ||
        bus.zero_out !== (exp_lo == 16'h0) || bus.write_back_ctrl_sgnl_out !== 16'h1111) begin
      nerr++;
      $display("FAIL %s_result: got valid=%b lo=%h hi=%h zero=%b wb=%h, required valid=1 lo=%h hi=%h wb=1111",
               name, bus.valid_out, bus.alu_result_out, bus.alu_hi_out, bus.zero_out,
               bus.write_back_ctrl_sgnl_out, exp_lo, exp_hi);
    end
  endtask

  task automatic test_mul();
    multi("mul", 4'd9, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 0, 0);
    bubble();
    step();
  endtask

  task automatic test_back_to_back();
    multi("b2b_mul", 4'd9, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 0, 0);
    multi("divu", 4'd10, 16'd100, 16'd7, 16'd14, 16'd2, 0, 0);
    multi("divu_zero", 4'd10, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 0, 0);
    bubble();
    step();
  endtask

  task automatic test_flush();
    drive(4'd9, 1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0);
    for (int i = 0; i < 9; i++) step();
    bus.flush = 1'b1;
    #1;
    nvec++;
    if (bus.stall_out !== 1'b0) begin
      nerr++;
      $display("FAIL flush_stall: got %b, required 0", bus.stall_out);
    end
    step();
    bus.flush = 1'b0;
    drive(4'd0, 1'b1, 1'b0, 16'd3, 16'd4, 16'h0);
    nvec++;
    if (bus.valid_out !== 1'b0 || bus.stall_out !== 1'b0) begin
      nerr++;
      $display("FAIL flush_idle: got valid=%b stall=%b, required 0 0", bus.valid_out, bus.stall_out);
    end
    step();
    nvec++;
    if (bus.valid_out !== 1'b1 || bus.alu_result_out !== 16'd7) begin
      nerr++;
      $display("FAIL flush_add: got valid=%b res=%h, required 1 0007", bus.valid_out, bus.alu_result_out);
    end
    bubble();
    step();
  endtask

  task automatic test_halt_reset();
    multi("halt_mul", 4'd9, 16'h1234, 16'h5678, 16'h0060, 16'h0626, 6, 3);
    single("pre_rst_add", 4'd0, 1'b0, 16'h0001, 16'h0002, 16'h0, 16'h0003);
    drive(4'd9, 1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    nvec++;
    if ({bus.write_back_ctrl_sgnl_out, bus.memory_ctrl_sgnl_out, bus.alu_result_out,
         bus.alu_hi_out, bus.store_data_out, bus.dest_reg_out, bus.zero_out,
         bus.valid_out} !== 86'd0) begin
      nerr++;
      $display("FAIL rst_mid_busy: got res=%h valid=%b wb=%h, required all zero",
               bus.alu_result_out, bus.valid_out, bus.write_back_ctrl_sgnl_out);
    end
    rst = 1'b0;
    single("post_rst_add", 4'd0, 1'b0, 16'h0010, 16'h0020, 16'h0, 16'h0030);
    bubble();
    step();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_back_to_back();
    test_flush();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
